// File: rtl/jtframe_lfbuf_mem_pkg.sv
// Shared defaults for the line-buffer storage block.
package jtframe_lfbuf_mem_pkg;

   // Default word width and line address width
   localparam int unsigned LfbufDefDw = 16;
   localparam int unsigned LfbufDefHw = 9;

endpackage

// File: rtl/lfbuf_bram.sv
// Generic single-clock simple dual-port RAM with a read-first registered output.
module lfbuf_bram #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] q_d, q_q;

   // Combinational array lookup feeding the output register
   always_comb begin
      q_d = mem[raddr];
   end

   // Output register; cleared by reset, array untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   // Array write port; writes are dropped while reset is held
   always_ff @(posedge clk) begin
      if (!rst && we) mem[waddr] <= wdata;
   end

   assign q = q_q;

endmodule

// File: rtl/jtframe_lfbuf_mem.sv
// Line-buffer storage: a banked true dual-port RAM for core/dump traffic and
// a simple dual-port output RAM for the fetched line read by hdump.
module jtframe_lfbuf_mem
   import jtframe_lfbuf_mem_pkg::*;
#(
   parameter int unsigned DW = LfbufDefDw,
   parameter int unsigned HW = LfbufDefHw
) (
   input  logic          clk,
   input  logic          rst,
   // dual RAM port 0
   input  logic [HW:0]   addr0,
   input  logic [DW-1:0] data0,
   input  logic          we0,
   output logic [DW-1:0] q0,
   // dual RAM port 1
   input  logic [HW:0]   addr1,
   input  logic [DW-1:0] data1,
   input  logic          we1,
   output logic [DW-1:0] q1,
   // output RAM
   input  logic [DW-1:0] din,
   input  logic [HW-1:0] wr_addr,
   input  logic          we,
   input  logic [HW-1:0] rd_addr,
   output logic [DW-1:0] dout
);

   // Address MSB selects the bank; the caller alternates banks per line
   logic [DW-1:0] mem [2**(HW+1)];
   logic [DW-1:0] q0_d, q0_q;
   logic [DW-1:0] q1_d, q1_q;

   // Read-first lookups on both ports
   always_comb begin
      q0_d = mem[addr0];
      q1_d = mem[addr1];
   end

   // Port output registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q0_q <= '0;
         q1_q <= '0;
      end else begin
         q0_q <= q0_d;
         q1_q <= q1_d;
      end
   end

   // Both write ports; port 1 is assigned last so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (we0) mem[addr0] <= data0;
         if (we1) mem[addr1] <= data1;
      end
   end

   assign q0 = q0_q;
   assign q1 = q1_q;

   lfbuf_bram #(
      .DW (DW),
      .AW (HW)
   ) u_out (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (wr_addr),
      .wdata (din),
      .raddr (rd_addr),
      .q     (dout)
   );

endmodule

// File: tb/tb_jtframe_lfbuf_mem.sv
// Self-checking bench: directed cases plus random traffic against an array model.
module tb_jtframe_lfbuf_mem;

   logic        clk;
   logic        rst;
   logic [9:0]  addr0, addr1;
   logic [15:0] data0, data1, din;
   logic        we0, we1, we;
   logic [8:0]  wr_addr, rd_addr;
   logic [15:0] q0, q1, dout;

   int unsigned n_vec;
   int unsigned n_err;

   // Reference state: plain arrays plus expected output values
   logic [15:0] dual_m [1024];
   logic [15:0] out_m  [512];
   logic [15:0] exp_q0, exp_q1, exp_dout;

   jtframe_lfbuf_mem #(
      .DW (16),
      .HW (9)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .addr0   (addr0),
      .data0   (data0),
      .we0     (we0),
      .q0      (q0),
      .addr1   (addr1),
      .data1   (data1),
      .we1     (we1),
      .q1      (q1),
      .din     (din),
      .wr_addr (wr_addr),
      .we      (we),
      .rd_addr (rd_addr),
      .dout    (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // One clock: update the model at the edge, then compare all outputs just after it
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         exp_q0 = '0; exp_q1 = '0; exp_dout = '0;
      end else begin
         exp_q0   = dual_m[addr0];
         exp_q1   = dual_m[addr1];
         exp_dout = out_m[rd_addr];
         if (we0) dual_m[addr0] = data0;
         if (we1) dual_m[addr1] = data1;
         if (we)  out_m[wr_addr] = din;
      end
      #1;
      check("q0", q0, exp_q0);
      check("q1", q1, exp_q1);
      check("dout", dout, exp_dout);
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; we = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      for (int i = 0; i < 1024; i++) dual_m[i] = '0;
      for (int i = 0; i < 512; i++)  out_m[i]  = '0;
      rst = 1'b1;
      addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; din = '0;
      wr_addr = '0; rd_addr = '0;
      idle();
      tick();
      tick();
      rst = 1'b0;

      // Clear every location so the model and the arrays agree regardless of power-up
      for (int i = 0; i < 512; i++) begin
         addr0 = 10'(i); addr1 = 10'(i + 512); data0 = '0; data1 = '0;
         we0 = 1'b1; we1 = 1'b1;
         wr_addr = 9'(i); din = '0; we = 1'b1; rd_addr = 9'(i);
         tick();
      end
      idle();

      // Port 1 write, port 0 read, then port 0 clears it
      addr1 = 10'h005; data1 = 16'h1234; we1 = 1'b1; tick();
      idle(); addr0 = 10'h005; tick();
      check("p1w_p0r", q0, 16'h1234);
      data0 = 16'h0000; we0 = 1'b1; tick();
      idle(); tick();
      check("p0_clear", q0, 16'h0000);

      // Bank separation
      addr0 = 10'h010; data0 = 16'hAAAA; we0 = 1'b1;
      addr1 = 10'h210; data1 = 16'h5555; we1 = 1'b1; tick();
      idle(); tick();
      check("bank0", q0, 16'hAAAA);
      check("bank1", q1, 16'h5555);

      // Read-during-write on the same port and across ports
      addr0 = 10'h020; data0 = 16'h1111; we0 = 1'b1; tick();
      idle(); data0 = 16'h2222; we0 = 1'b1; addr1 = 10'h020; tick();
      check("rdw_same", q0, 16'h1111);
      check("rdw_cross", q1, 16'h1111);
      idle(); tick();
      check("rdw_after0", q0, 16'h2222);
      check("rdw_after1", q1, 16'h2222);

      // Write collision: port 1 wins
      addr0 = 10'h300; addr1 = 10'h300; data0 = 16'h00AA; data1 = 16'h00BB;
      we0 = 1'b1; we1 = 1'b1; tick();
      idle(); tick();
      check("collide0", q0, 16'h00BB);
      check("collide1", q1, 16'h00BB);

      // Output RAM streaming, reading one address behind the writer
      for (int i = 0; i < 512; i++) begin
         logic [15:0] v;
         wr_addr = 9'(i); din = 16'(i * 3); we = 1'b1;
         rd_addr = 9'(i - 1);
         tick();
         v = 16'((i - 1) * 3);
         if (i > 0) check("stream", dout, v);
      end
      // Same-address read during write returns the old value
      wr_addr = 9'd5; rd_addr = 9'd5; din = 16'hBEEF; we = 1'b1; tick();
      check("out_rdw", dout, 16'd15);
      idle(); tick();
      check("out_new", dout, 16'hBEEF);

      // Reset mid-read: outputs drop at once, writes ignored, contents kept
      addr0 = 10'h010; addr1 = 10'h210; rd_addr = 9'd5; tick();
      #2 rst = 1'b1;
      #1;
      check("rst_q0", q0, 16'h0000);
      check("rst_q1", q1, 16'h0000);
      check("rst_dout", dout, 16'h0000);
      data0 = 16'hDEAD; we0 = 1'b1; data1 = 16'hDEAD; we1 = 1'b1;
      din = 16'hDEAD; wr_addr = 9'd5; we = 1'b1;
      tick();
      idle();
      rst = 1'b0;
      tick();
      check("rst_keep0", q0, 16'hAAAA);
      check("rst_keep1", q1, 16'h5555);
      check("rst_keepo", dout, 16'hBEEF);

      // Random traffic, biased toward a few addresses so collisions occur
      for (int i = 0; i < 3000; i++) begin
         addr0 = {1'($urandom), 9'($urandom_range(0, 7))};
         addr1 = {1'($urandom), 9'($urandom_range(0, 7))};
         if ($urandom_range(0, 3) == 0) addr0 = 10'($urandom);
         data0 = 16'($urandom); data1 = 16'($urandom); din = 16'($urandom);
         we0 = 1'($urandom); we1 = 1'($urandom); we = 1'($urandom);
         wr_addr = 9'($urandom_range(0, 7));
         rd_addr = 9'($urandom_range(0, 7));
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
